instruction_decode_stage: RTL and testbench

Parametrised ID pipeline stage for the 16-bit pipelined core, placed between instruction fetch / branch predictor and execute.
- Decodes the fixed 16-bit instruction format and issues register-file read indices combinationally.
- Registers all decoded fields into the ID/EX boundary.
- Adds valid/stall/flush handshaking, load-use hazard bubbles and branch/jump target computation; the previous ID stage had none of these.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/id_decoder.sv | 48 ++++
 rtl/instruction_decode_stage.sv | 149 ++++++++++++++
 tb/tb_instruction_decode_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: instruction field positions, opcodes
// and the ID-stage control word layout.
package core_pkg;

    localparam int INSTR_W   = 16;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 4;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RS1_HI = 11;
    localparam int RS1_LO = 7;
    localparam int RS2_HI = 6;
    localparam int RS2_LO = 2;
    localparam int JMP_FIELD_W = 12;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_AND  = 4'h3;
    localparam logic [3:0] OPC_OR   = 4'h4;
    localparam logic [3:0] OPC_ADDI = 4'h5;
    localparam logic [3:0] OPC_LD   = 4'h6;
    localparam logic [3:0] OPC_ST   = 4'h7;
    localparam logic [3:0] OPC_BEQZ = 4'h8;
    localparam logic [3:0] OPC_JMP  = 4'h9;

    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_READ  = 2;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_BRANCH    = 0;

    localparam logic [CTRL_W-1:0] CTRL_NONE  = 4'b0000;
    localparam logic [CTRL_W-1:0] CTRL_ALU   = 4'b1000;
    localparam logic [CTRL_W-1:0] CTRL_LOAD  = 4'b1100;
    localparam logic [CTRL_W-1:0] CTRL_STORE = 4'b0010;
    localparam logic [CTRL_W-1:0] CTRL_BR    = 4'b0001;

    typedef struct packed {
        logic [CTRL_W-1:0] control;
        logic              illegal;
        logic              reads_reg1;
        logic              reads_reg2;
    } decode_t;

endpackage

// File: rtl/id_decoder.sv
// Pure combinational opcode decode: control word, illegal flag and which
// register-file ports the instruction actually reads.
module id_decoder
    import core_pkg::*;
(
    input  logic [3:0] opcode,
    output decode_t    decode
);

    // Illegal opcodes behave as NOP and read nothing, so they never cause a bubble.
    always_comb begin
        decode = '{control: CTRL_NONE, illegal: 1'b0, reads_reg1: 1'b0, reads_reg2: 1'b0};
        case (opcode)
            OPC_NOP: begin
            end
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
                decode.control    = CTRL_ALU;
                decode.reads_reg1 = 1'b1;
                decode.reads_reg2 = 1'b1;
            end
            OPC_ADDI: begin
                decode.control    = CTRL_ALU;
                decode.reads_reg1 = 1'b1;
            end
            OPC_LD: begin
                decode.control    = CTRL_LOAD;
                decode.reads_reg1 = 1'b1;
                decode.reads_reg2 = 1'b1;
            end
            OPC_ST: begin
                decode.control    = CTRL_STORE;
                decode.reads_reg1 = 1'b1;
                decode.reads_reg2 = 1'b1;
            end
            OPC_BEQZ: begin
                decode.control    = CTRL_BR;
                decode.reads_reg1 = 1'b1;
            end
            OPC_JMP: begin
                decode.control    = CTRL_BR;
            end
            default: begin
                decode.illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// ID pipeline stage: decode, RF index issue, ID/EX register with stall/flush and
// load-use bubbles. Optional writeback bypass enabled by ID_WB_BYPASS_EN.
module instruction_decode_stage
    import core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 14,
    parameter int IMM_W  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_if,
    input  logic [PC_W-1:0]      next_program_counter_if,
    input  logic [INSTR_W-1:0]   instruction_if,
    input  logic                 branch_prediction_bp,
    input  logic [DATA_W-1:0]    reg1_data_rf,
    input  logic [DATA_W-1:0]    reg2_data_rf,
    input  logic                 stall_ex,
    input  logic                 flush_ex,
`ifdef ID_WB_BYPASS_EN
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_idx,
    input  logic [DATA_W-1:0]    wb_data,
`endif
    output logic [REG_IDX_W-1:0] reg1_index_rf,
    output logic [REG_IDX_W-1:0] reg2_index_rf,
    output logic                 stall_if,
    output logic                 valid_id,
    output logic [3:0]           opcode_id,
    output logic [PC_W-1:0]      target_address_id,
    output logic [PC_W-1:0]      next_program_counter_id,
    output logic [DATA_W-1:0]    reg1_data_id,
    output logic [DATA_W-1:0]    reg2_data_id,
    output logic [REG_IDX_W-1:0] dest_reg_index_id,
    output logic [DATA_W-1:0]    immediate_id,
    output logic [CTRL_W-1:0]    control_id,
    output logic                 prediction_id,
    output logic                 illegal_id
);

    logic [3:0]           opcode;
    decode_t              decode;
    logic                 hazard;
    logic [CTRL_W-1:0]    load_control;
    logic [REG_IDX_W-1:0] load_dest;
    logic [DATA_W-1:0]    imm_data;
    logic [PC_W-1:0]      imm_pc;
    logic [PC_W-1:0]      jmp_target;
    logic [PC_W-1:0]      load_target;
    logic [DATA_W-1:0]    operand1;
    logic [DATA_W-1:0]    operand2;

    assign opcode        = instruction_if[OPC_HI:OPC_LO];
    assign reg1_index_rf = instruction_if[RS1_HI:RS1_LO];
    assign reg2_index_rf = instruction_if[RS2_HI:RS2_LO];

    id_decoder u_id_decoder (
        .opcode (opcode),
        .decode (decode)
    );

    assign imm_data = {{(DATA_W-IMM_W){instruction_if[IMM_W-1]}}, instruction_if[IMM_W-1:0]};
    assign imm_pc   = {{(PC_W-IMM_W){instruction_if[IMM_W-1]}}, instruction_if[IMM_W-1:0]};

    // JMP keeps the upper PC bits of the current region and replaces the low 12.
    generate
        if (PC_W > JMP_FIELD_W) begin : g_jmp_region
            assign jmp_target = {next_program_counter_if[PC_W-1:JMP_FIELD_W],
                                 instruction_if[JMP_FIELD_W-1:0]};
        end else begin : g_jmp_flat
            assign jmp_target = instruction_if[JMP_FIELD_W-1:0];
        end
    endgenerate

    always_comb begin
        load_target = '0;
        case (opcode)
            OPC_BEQZ: load_target = next_program_counter_if + imm_pc;
            OPC_JMP:  load_target = jmp_target;
            default:  load_target = '0;
        endcase
    end

    assign load_control = valid_if ? decode.control : CTRL_NONE;
    assign load_dest    = load_control[CTRL_REG_WRITE] ? reg1_index_rf : '0;

`ifdef ID_WB_BYPASS_EN
    // A same-cycle writeback wins over the (stale) register-file read, per port.
    always_comb begin
        operand1 = reg1_data_rf;
        operand2 = reg2_data_rf;
        if (wb_we && (wb_idx != '0) && (wb_idx == reg1_index_rf)) begin
            operand1 = wb_data;
        end
        if (wb_we && (wb_idx != '0) && (wb_idx == reg2_index_rf)) begin
            operand2 = wb_data;
        end
    end
`else
    assign operand1 = reg1_data_rf;
    assign operand2 = reg2_data_rf;
`endif

    // A load in ID whose destination the incoming instruction reads must wait a cycle.
    always_comb begin
        hazard = valid_id && control_id[CTRL_MEM_READ] && (dest_reg_index_id != '0) && valid_if &&
                 ((decode.reads_reg1 && (reg1_index_rf == dest_reg_index_id)) ||
                  (decode.reads_reg2 && (reg2_index_rf == dest_reg_index_id)));
    end

    assign stall_if = !flush_ex && (stall_ex || hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_id                <= 1'b0;
            opcode_id               <= '0;
            target_address_id       <= '0;
            next_program_counter_id <= '0;
            reg1_data_id            <= '0;
            reg2_data_id            <= '0;
            dest_reg_index_id       <= '0;
            immediate_id            <= '0;
            control_id              <= '0;
            prediction_id           <= 1'b0;
            illegal_id              <= 1'b0;
        end else if (flush_ex) begin
            valid_id   <= 1'b0;
            control_id <= '0;
        end else if (!stall_ex) begin
            if (hazard) begin
                valid_id   <= 1'b0;
                control_id <= '0;
            end else begin
                valid_id                <= valid_if;
                opcode_id               <= opcode;
                target_address_id       <= load_target;
                next_program_counter_id <= next_program_counter_if;
                reg1_data_id            <= operand1;
                reg2_data_id            <= operand2;
                dest_reg_index_id       <= load_dest;
                immediate_id            <= imm_data;
                control_id              <= load_control;
                prediction_id           <= branch_prediction_bp;
                illegal_id              <= decode.illegal;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: directed vector table, reset
// corner cases, optional bypass checks and a randomized run against a reference model.
module tb_instruction_decode_stage;

    localparam int DATA_W = 16;
    localparam int PC_W   = 14;
    localparam int IMM_W  = 7;
    localparam int NV     = 22;
    localparam int NRAND  = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_if;
    logic [PC_W-1:0]   next_program_counter_if;
    logic [15:0]       instruction_if;
    logic              branch_prediction_bp;
    logic [DATA_W-1:0] reg1_data_rf;
    logic [DATA_W-1:0] reg2_data_rf;
    logic              stall_ex;
    logic              flush_ex;
`ifdef ID_WB_BYPASS_EN
    logic              wb_we;
    logic [4:0]        wb_idx;
    logic [DATA_W-1:0] wb_data;
`endif
    logic [4:0]        reg1_index_rf;
    logic [4:0]        reg2_index_rf;
    logic              stall_if;
    logic              valid_id;
    logic [3:0]        opcode_id;
    logic [PC_W-1:0]   target_address_id;
    logic [PC_W-1:0]   next_program_counter_id;
    logic [DATA_W-1:0] reg1_data_id;
    logic [DATA_W-1:0] reg2_data_id;
    logic [4:0]        dest_reg_index_id;
    logic [DATA_W-1:0] immediate_id;
    logic [3:0]        control_id;
    logic              prediction_id;
    logic              illegal_id;

    always #5 clk = ~clk;

    instruction_decode_stage #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .IMM_W  (IMM_W)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .valid_if                (valid_if),
        .next_program_counter_if (next_program_counter_if),
        .instruction_if          (instruction_if),
        .branch_prediction_bp    (branch_prediction_bp),
        .reg1_data_rf            (reg1_data_rf),
        .reg2_data_rf            (reg2_data_rf),
        .stall_ex                (stall_ex),
        .flush_ex                (flush_ex),
`ifdef ID_WB_BYPASS_EN
        .wb_we                   (wb_we),
        .wb_idx                  (wb_idx),
        .wb_data                 (wb_data),
`endif
        .reg1_index_rf           (reg1_index_rf),
        .reg2_index_rf           (reg2_index_rf),
        .stall_if                (stall_if),
        .valid_id                (valid_id),
        .opcode_id               (opcode_id),
        .target_address_id       (target_address_id),
        .next_program_counter_id (next_program_counter_id),
        .reg1_data_id            (reg1_data_id),
        .reg2_data_id            (reg2_data_id),
        .dest_reg_index_id       (dest_reg_index_id),
        .immediate_id            (immediate_id),
        .control_id              (control_id),
        .prediction_id           (prediction_id),
        .illegal_id              (illegal_id)
    );

    // Expected ID register contents; 'full' says whether the non-control fields are defined.
    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [3:0]  ctrl;
        logic [4:0]  dest;
        logic [13:0] tgt;
        logic [15:0] imm;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        pred;
        logic [13:0] npc;
        logic        ill;
        logic        full;
    } ms_t;

    typedef struct {
        logic [15:0] instr;
        logic [13:0] npc;
        logic        v;
        logic        p;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        st;
        logic        fl;
        logic        e_sif;
        ms_t         e;
    } tv_t;

    tv_t tv [NV];
    int  total = 0;
    int  bad   = 0;

    function automatic ms_t zeroState();
        ms_t z;
        z = '{valid: 1'b0, op: 4'h0, ctrl: 4'h0, dest: 5'h0, tgt: 14'h0, imm: 16'h0,
              d1: 16'h0, d2: 16'h0, pred: 1'b0, npc: 14'h0, ill: 1'b0, full: 1'b1};
        return z;
    endfunction

    function automatic tv_t mk(int instr, int npc, int v, int p, int d1, int d2, int st, int fl,
                               int sif, int valid, int op, int ctrl, int dest, int tgt, int imm,
                               int ed1, int ed2, int pred, int enpc, int ill);
        tv_t r;
        r.instr = instr[15:0]; r.npc = npc[13:0]; r.v = v[0]; r.p = p[0];
        r.d1 = d1[15:0]; r.d2 = d2[15:0]; r.st = st[0]; r.fl = fl[0]; r.e_sif = sif[0];
        r.e.valid = valid[0]; r.e.op = op[3:0]; r.e.ctrl = ctrl[3:0]; r.e.dest = dest[4:0];
        r.e.tgt = tgt[13:0]; r.e.imm = imm[15:0]; r.e.d1 = ed1[15:0]; r.e.d2 = ed2[15:0];
        r.e.pred = pred[0]; r.e.npc = enpc[13:0]; r.e.ill = ill[0]; r.e.full = 1'b1;
        return r;
    endfunction

    // Bubble / flush rows: only valid and control are defined afterwards.
    function automatic tv_t part(int instr, int npc, int v, int p, int d1, int d2, int st, int fl, int sif);
        tv_t r;
        r = mk(instr, npc, v, p, d1, d2, st, fl, sif, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        r.e.full = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] mctrl(logic [3:0] op);
        logic [3:0] tab [16] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'hC, 4'h2,
                                 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        return tab[op];
    endfunction

    function automatic logic mreads1(logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic mreads2(logic [3:0] op);
        return ((op >= 4'd1) && (op <= 4'd4)) || (op == 4'd6) || (op == 4'd7);
    endfunction

    function automatic logic mhazard(ms_t s, logic [15:0] instr, logic v);
        logic [3:0] op;
        op = instr[15:12];
        return s.valid && s.ctrl[2] && (s.dest != 5'd0) && v &&
               ((mreads1(op) && (instr[11:7] == s.dest)) || (mreads2(op) && (instr[6:2] == s.dest)));
    endfunction

    function automatic ms_t modelNext(ms_t s, logic [15:0] instr, logic [13:0] npc, logic v, logic p,
                                      logic [15:0] d1, logic [15:0] d2, logic st, logic fl);
        ms_t n;
        int  simm;
        int  t;
        logic [3:0] op;
        n  = s;
        op = instr[15:12];
        simm = $signed(instr[6:0]);
        if (fl || (!st && mhazard(s, instr, v))) begin
            n.valid = 1'b0;
            n.ctrl  = 4'h0;
            n.full  = 1'b0;
        end else if (!st) begin
            n.valid = v;
            n.op    = op;
            n.ctrl  = v ? mctrl(op) : 4'h0;
            n.dest  = n.ctrl[3] ? instr[11:7] : 5'd0;
            n.ill   = (op >= 4'd10);
            t       = int'(npc) + simm;
            if (op == 4'd8)      n.tgt = t[13:0];
            else if (op == 4'd9) n.tgt = {npc[13:12], instr[11:0]};
            else                 n.tgt = 14'h0;
            n.imm   = simm[15:0];
            n.d1    = d1;
            n.d2    = d2;
            n.pred  = p;
            n.npc   = npc;
            n.full  = 1'b1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic checkState(input string tag, input ms_t e);
        checkOutput({tag, " valid_id"}, 32'(valid_id), 32'(e.valid));
        checkOutput({tag, " control_id"}, 32'(control_id), 32'(e.ctrl));
        if (e.full) begin
            checkOutput({tag, " opcode_id"}, 32'(opcode_id), 32'(e.op));
            checkOutput({tag, " dest"}, 32'(dest_reg_index_id), 32'(e.dest));
            checkOutput({tag, " target"}, 32'(target_address_id), 32'(e.tgt));
            checkOutput({tag, " immediate"}, 32'(immediate_id), 32'(e.imm));
            checkOutput({tag, " reg1_data"}, 32'(reg1_data_id), 32'(e.d1));
            checkOutput({tag, " reg2_data"}, 32'(reg2_data_id), 32'(e.d2));
            checkOutput({tag, " prediction"}, 32'(prediction_id), 32'(e.pred));
            checkOutput({tag, " next_pc"}, 32'(next_program_counter_id), 32'(e.npc));
            checkOutput({tag, " illegal"}, 32'(illegal_id), 32'(e.ill));
        end
    endtask

    task automatic applyStimulus(input logic [15:0] instr, input logic [13:0] npc, input logic v,
                                 input logic p, input logic [15:0] d1, input logic [15:0] d2,
                                 input logic st, input logic fl);
        @(negedge clk);
        instruction_if          = instr;
        next_program_counter_if = npc;
        valid_if                = v;
        branch_prediction_bp    = p;
        reg1_data_rf            = d1;
        reg2_data_rf            = d2;
        stall_ex                = st;
        flush_ex                = fl;
        #1;
    endtask

    initial begin
        ms_t mst;
        ms_t nst;
        logic [15:0] rinstr;
        logic [13:0] rnpc;
        logic [15:0] rd1, rd2;
        logic rv, rp, rst_x, rfl;

        //         instr     npc      v  p  d1  d2  st fl | sif vld op   ctrl dest tgt      imm      d1  d2  pr npc      ill
        tv[0]  = mk(16'h1088, 1,       1, 0, 1,  2,  0, 0,   0,  1,  1,   8,   1,   0,       'h0008,  1,  2,  0, 1,       0);
        tv[1]  = mk(16'h807E, 5,       1, 1, 10, 20, 0, 0,   0,  1,  8,   1,   0,   'h0003,  'hFFFE,  10, 20, 1, 5,       0);
        tv[2]  = mk(16'h9ABC, 'h3001,  1, 0, 3,  4,  0, 0,   0,  1,  9,   1,   0,   'h3ABC,  'h003C,  3,  4,  0, 'h3001,  0);
        tv[3]  = mk(16'h6188, 10,      1, 0, 5,  6,  0, 0,   0,  1,  6,   'hC, 3,   0,       'h0008,  5,  6,  0, 10,      0);
        tv[4]  = part(16'h1190, 11,    1, 0, 7,  8,  0, 0,   1);
        tv[5]  = mk(16'h1190, 11,      1, 0, 7,  8,  0, 0,   0,  1,  1,   8,   3,   0,       'h0010,  7,  8,  0, 11,      0);
        tv[6]  = mk(16'h2000, 12,      1, 1, 99, 99, 1, 0,   1,  1,  1,   8,   3,   0,       'h0010,  7,  8,  0, 11,      0);
        tv[7]  = mk(16'h3000, 13,      1, 1, 99, 99, 1, 0,   1,  1,  1,   8,   3,   0,       'h0010,  7,  8,  0, 11,      0);
        tv[8]  = mk(16'h4000, 14,      1, 1, 99, 99, 1, 0,   1,  1,  1,   8,   3,   0,       'h0010,  7,  8,  0, 11,      0);
        tv[9]  = mk(16'h2084, 20,      1, 0, 9,  10, 0, 0,   0,  1,  2,   8,   1,   0,       'h0004,  9,  10, 0, 20,      0);
        tv[10] = mk(16'h6280, 21,      1, 0, 11, 12, 0, 0,   0,  1,  6,   'hC, 5,   0,       'h0000,  11, 12, 0, 21,      0);
        tv[11] = part(16'h1294, 22,    1, 0, 1,  1,  1, 1,   0);
        tv[12] = mk(16'hF000, 30,      1, 0, 13, 14, 0, 0,   0,  1,  'hF, 0,   0,   0,       'h0000,  13, 14, 0, 30,      1);
        tv[13] = mk(16'h1088, 31,      0, 0, 15, 16, 0, 0,   0,  0,  1,   0,   0,   0,       'h0008,  15, 16, 0, 31,      0);
        tv[14] = mk(16'h80FC, 1,       1, 1, 17, 18, 0, 0,   0,  1,  8,   1,   0,   'h3FFD,  'hFFFC,  17, 18, 1, 1,       0);
        tv[15] = mk(16'h8003, 'h3FFF,  1, 0, 19, 20, 0, 0,   0,  1,  8,   1,   0,   'h0002,  'h0003,  19, 20, 0, 'h3FFF,  0);
        tv[16] = mk(16'h710C, 40,      1, 0, 21, 22, 0, 0,   0,  1,  7,   2,   0,   0,       'h000C,  21, 22, 0, 40,      0);
        tv[17] = mk(16'h6204, 41,      1, 0, 23, 24, 0, 0,   0,  1,  6,   'hC, 4,   0,       'h0004,  23, 24, 0, 41,      0);
        tv[18] = part(16'h7090, 42,    1, 0, 25, 26, 0, 0,   1);
        tv[19] = mk(16'h7090, 42,      1, 0, 25, 26, 0, 0,   0,  1,  7,   2,   0,   0,       'h0010,  25, 26, 0, 42,      0);
        tv[20] = mk(16'h6300, 43,      1, 0, 27, 28, 0, 0,   0,  1,  6,   'hC, 6,   0,       'h0000,  27, 28, 0, 43,      0);
        tv[21] = mk(16'h5098, 44,      1, 0, 29, 30, 0, 0,   0,  1,  5,   8,   1,   0,       'h0018,  29, 30, 0, 44,      0);

        rst = 1'b1;
        instruction_if = '0; next_program_counter_if = '0; valid_if = 1'b0;
        branch_prediction_bp = 1'b0; reg1_data_rf = '0; reg2_data_rf = '0;
        stall_ex = 1'b0; flush_ex = 1'b0;
`ifdef ID_WB_BYPASS_EN
        wb_we = 1'b0; wb_idx = '0; wb_data = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkState("reset", zeroState());
        checkOutput("reset stall_if", 32'(stall_if), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(tv[i].instr, tv[i].npc, tv[i].v, tv[i].p, tv[i].d1, tv[i].d2, tv[i].st, tv[i].fl);
            checkOutput($sformatf("row%0d stall_if", i), 32'(stall_if), 32'(tv[i].e_sif));
            checkOutput($sformatf("row%0d reg1_index", i), 32'(reg1_index_rf), 32'(tv[i].instr[11:7]));
            checkOutput($sformatf("row%0d reg2_index", i), 32'(reg2_index_rf), 32'(tv[i].instr[6:2]));
            @(posedge clk);
            #1;
            checkState($sformatf("row%0d", i), tv[i].e);
        end

        // Reset arriving while EX stalls: state clears at once, stall_if follows inputs only.
        applyStimulus(16'h6300, 50, 1, 0, 1, 1, 1, 0);
        checkOutput("pre-reset stall_if", 32'(stall_if), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkState("midstall reset", zeroState());
        checkOutput("midstall reset stall_if", 32'(stall_if), 32'd1);
        stall_ex = 1'b0;
        #1;
        checkOutput("midstall reset stall_if released", 32'(stall_if), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ID_WB_BYPASS_EN
        wb_we = 1'b1; wb_idx = 5'd1; wb_data = 16'hBEEF;
        applyStimulus(16'h1088, 1, 1, 0, 16'h0001, 16'h0002, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("bypass reg1_data", 32'(reg1_data_id), 32'hBEEF);
        checkOutput("bypass reg2_data", 32'(reg2_data_id), 32'h0002);
        wb_idx = 5'd0;
        applyStimulus(16'h1008, 2, 1, 0, 16'h0033, 16'h0044, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("bypass idx0 reg1_data", 32'(reg1_data_id), 32'h0033);
        checkOutput("bypass idx0 reg2_data", 32'(reg2_data_id), 32'h0044);
        wb_we = 1'b0;
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
`endif

        mst = zeroState();
        for (int c = 0; c < NRAND; c++) begin
            rinstr = {4'($urandom_range(0, 15)), 3'b000, 2'($urandom_range(0, 3)),
                      3'b000, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            rnpc  = 14'($urandom);
            rd1   = 16'($urandom);
            rd2   = 16'($urandom);
            rv    = ($urandom_range(0, 7) != 0);
            rp    = 1'($urandom);
            rst_x = ($urandom_range(0, 5) == 0);
            rfl   = ($urandom_range(0, 7) == 0);
            applyStimulus(rinstr, rnpc, rv, rp, rd1, rd2, rst_x, rfl);
            checkOutput($sformatf("rand%0d stall_if", c), 32'(stall_if),
                        32'(!rfl && (rst_x || mhazard(mst, rinstr, rv))));
            checkOutput($sformatf("rand%0d reg1_index", c), 32'(reg1_index_rf), 32'(rinstr[11:7]));
            nst = modelNext(mst, rinstr, rnpc, rv, rp, rd1, rd2, rst_x, rfl);
            @(posedge clk);
            #1;
            mst = nst;
            checkState($sformatf("rand%0d", c), mst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
